// File: rtl/sram_1rw1r_param_fwd.sv
// sram_1rw1r_param_fwd: single-clock 1RW + 1R synchronous SRAM model.
// It fills the whole array with INIT_VALUE after reset. Port 1 can forward a
// same-edge port-0 write and flags the address collision.
//
// Ports:
//   clk0       in   shared clock, rising edge
//   rst0       in   asynchronous active-high reset
//   init_done  out  1 once the init sweep has finished and ports accept requests
//   csb0       in   port 0 chip select, active low
//   web0       in   port 0 write enable, active low
//   wmask0     in   port 0 lane write mask, 1 = write lane
//   addr0      in   port 0 address
//   din0       in   port 0 write data
//   dout0      out  port 0 read data, registered, holds when idle
//   csb1       in   port 1 chip select, active low
//   addr1      in   port 1 address
//   dout1      out  port 1 read data, registered, holds when idle
//   collision  out  pulse: same-edge port-0 write and port-1 read, same address
module sram_1rw1r_param_fwd #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 9,
  parameter int unsigned           LANE_WIDTH = 8,
  parameter bit                    FWD_EN     = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned NUM_WMASKS = (LANE_WIDTH == 0) ? 1 : DATA_WIDTH / LANE_WIDTH,
  localparam int unsigned RAM_DEPTH  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst0,
  output logic                  init_done,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  collision
);

  // Reject lane geometries that cannot tile the word.
  if ((LANE_WIDTH == 0) ? 1'b1 : ((DATA_WIDTH % LANE_WIDTH) != 0)) begin : g_param_check
    $fatal(1, "sram_1rw1r_param_fwd: DATA_WIDTH must be a non-zero multiple of LANE_WIDTH");
  end

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  ready, wr0, rd0, rd1, coll;
  logic [DATA_WIDTH-1:0] lane_mask, wr_word, fwd_word;

  // Next-state logic: sweep one word per edge, then stay ready until reset.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
      if (ptr_q == '1) begin
        state_d = ST_READY;
      end
    end
  end

  // Request decode; both chip selects are ignored until the sweep finishes.
  always_comb begin
    ready = (state_q == ST_READY);
    wr0   = ready && !csb0 && !web0;
    rd0   = ready && !csb0 && web0;
    rd1   = ready && !csb1;
    coll  = wr0 && rd1 && (addr0 == addr1);
  end

  // Expand lane mask to bits; the merged word is what port 0 stores and,
  // on a collision with forwarding enabled, what port 1 returns.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      lane_mask[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wmask0[i]}};
    end
    wr_word  = (mem[addr0] & ~lane_mask) | (din0 & lane_mask);
    fwd_word = (FWD_EN && coll) ? wr_word : mem[addr1];
  end

  // Array write port. While rst0 is held the sweep keeps rewriting word 0,
  // which is harmless because the sweep restarts there on release.
  always_ff @(posedge clk0) begin
    if (state_q == ST_INIT) begin
      mem[ptr_q] <= INIT_VALUE;
    end else if (wr0) begin
      mem[addr0] <= wr_word;
    end
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q   <= ST_INIT;
      ptr_q     <= '0;
      init_done <= 1'b0;
      collision <= 1'b0;
      dout0     <= '0;
      dout1     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      init_done <= (state_d == ST_READY);
      collision <= coll;
      if (rd0) begin
        dout0 <= mem[addr0];
      end
      if (rd1) begin
        dout1 <= fwd_word;
      end
    end
  end

endmodule
